// File: rtl/pwm_fade_pkg.sv
// Shared types and constants for the PWM duty-cycle fade sequencer.
package pwm_fade_pkg;

    localparam int unsigned DUTY_W     = 8;
    localparam int unsigned DEF_DIV_W  = 16;
    localparam int unsigned DEF_STEP_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_fade_tick.sv
// Rate divider: while enabled, emits one tick every reload+1 clocks.
module pwm_fade_tick
    import pwm_fade_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] reload,
    output logic             tick_c
);

    logic [DIV_W-1:0] count;

    assign tick_c = enable && (count == reload);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick_c ? '0 : count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Ramps the PWM duty cycle toward a commanded target in steps paced by a
// programmable divider; supports abort (freeze) and mid-ramp retarget.
module pwm_fade_sequencer
    import pwm_fade_pkg::*;
#(
    parameter int unsigned DIV_W  = DEF_DIV_W,
    parameter int unsigned STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] cfg_target,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              busy,
    output logic              done
);

    localparam int unsigned EXT_W = DUTY_W + 1;

    state_t            state, state_nxt;
    logic [DUTY_W-1:0] target_q, target_nxt;
    logic [STEP_W-1:0] step_q, step_nxt;
    logic [DIV_W-1:0]  div_q, div_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    logic              busy_nxt;
    logic              done_arm, done_arm_nxt;
    logic              done_nxt;

    logic              start_c;
    logic              tick_c;
    logic [EXT_W-1:0]  up_sum_c;
    logic [EXT_W-1:0]  dn_diff_c;
    logic [DUTY_W-1:0] stepped_c;

    // Abort always wins over a coincident start.
    assign start_c = cfg_start && !cfg_abort;

    pwm_fade_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_c),
        .enable (state == RAMP),
        .reload (div_q),
        .tick_c (tick_c)
    );

    // Next duty value, clamped at the target; 9-bit math prevents wrap.
    always_comb begin
        up_sum_c  = EXT_W'(duty_cycle) + EXT_W'(step_q);
        dn_diff_c = EXT_W'(duty_cycle) - EXT_W'(step_q);
        stepped_c = target_q;
        if (target_q > duty_cycle) begin
            if (up_sum_c < EXT_W'(target_q)) begin
                stepped_c = up_sum_c[DUTY_W-1:0];
            end
        end else begin
            if (!dn_diff_c[DUTY_W] && (dn_diff_c > EXT_W'(target_q))) begin
                stepped_c = dn_diff_c[DUTY_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        target_nxt   = target_q;
        step_nxt     = step_q;
        div_nxt      = div_q;
        duty_nxt     = duty_cycle;
        busy_nxt     = busy;
        done_arm_nxt = 1'b0;
        done_nxt     = done_arm;

        if (start_c) begin
            target_nxt = cfg_target;
            step_nxt   = (cfg_step == '0) ? STEP_W'(1) : cfg_step;
            div_nxt    = cfg_div;
            if (cfg_target != duty_cycle) begin
                state_nxt = RAMP;
                busy_nxt  = 1'b1;
            end else begin
                state_nxt    = IDLE;
                busy_nxt     = 1'b0;
                done_arm_nxt = 1'b1;
            end
        end else begin
            case (state)
                RAMP: begin
                    if (cfg_abort) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else if (tick_c) begin
                        duty_nxt = stepped_c;
                        if (stepped_c == target_q) begin
                            state_nxt    = IDLE;
                            busy_nxt     = 1'b0;
                            done_arm_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            target_q   <= '0;
            step_q     <= '0;
            div_q      <= '0;
            duty_cycle <= '0;
            busy       <= 1'b0;
            done_arm   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            target_q   <= target_nxt;
            step_q     <= step_nxt;
            div_q      <= div_nxt;
            duty_cycle <= duty_nxt;
            busy       <= busy_nxt;
            done_arm   <= done_arm_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer: every change of {duty,busy,done}
// is matched against a queue of hand-derived (edge, value) expectations.
module tb_pwm_fade_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_target;
    logic [3:0]  cfg_step;
    logic [15:0] cfg_div;
    logic        cfg_start;
    logic        cfg_abort;
    logic [7:0]  duty_cycle;
    logic        busy;
    logic        done;

    pwm_fade_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_target (cfg_target),
        .cfg_step   (cfg_step),
        .cfg_div    (cfg_div),
        .cfg_start  (cfg_start),
        .cfg_abort  (cfg_abort),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] duty;
        logic       busy;
        logic       done;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en  = 1'b0;
    bit   end_req = 1'b0;

    // Edge counter: after edge N, cyc==N when sampled on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sole owner of the pass/fail counters.
    bit         armed    = 1'b0;
    bit         end_done = 1'b0;
    logic [9:0] prev;
    ev_t        e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!armed) begin
                armed = 1'b1;
                prev  = 10'h000;
                total++;
                if ({duty_cycle, busy, done} !== 10'h000) begin
                    bad++;
                    $display("FAIL reset_state got duty=%h busy=%b done=%b want duty=00 busy=0 done=0",
                             duty_cycle, busy, done);
                end
            end else if ({duty_cycle, busy, done} !== prev) begin
                prev = {duty_cycle, busy, done};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change edge=%0d got duty=%h busy=%b done=%b want no change",
                             cyc, duty_cycle, busy, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.duty !== duty_cycle || e.busy !== busy || e.done !== done) begin
                        bad++;
                        $display("FAIL event got edge=%0d duty=%h busy=%b done=%b want edge=%0d duty=%h busy=%b done=%b",
                                 cyc, duty_cycle, busy, done, e.cyc, e.duty, e.busy, e.done);
                    end
                end
            end
            if (end_req && !end_done) begin
                end_done = 1'b1;
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL leftover_events got %0d pending want 0 (next edge=%0d duty=%h)",
                             exp_q.size(), exp_q[0].cyc, exp_q[0].duty);
                end
            end
        end
    end

    task automatic ev(input int c, input logic [7:0] d, input logic b, input logic dn);
        ev_t x;
        x.cyc = c; x.duty = d; x.busy = b; x.done = dn;
        exp_q.push_back(x);
    endtask

    // Ramp whose intermediate values form a progression of n_mid entries,
    // landing on hand-chosen final value, followed by the done pulse.
    task automatic ramp_ev(input int s, input int div, input logic [7:0] from,
                           input int delta, input int n_mid, input logic [7:0] fin);
        int tf;
        ev(s, from, 1'b1, 1'b0);
        for (int k = 1; k <= n_mid; k++) begin
            ev(s + k * (div + 1), 8'(int'(from) + k * delta), 1'b1, 1'b0);
        end
        tf = s + (n_mid + 1) * (div + 1);
        ev(tf,     fin, 1'b0, 1'b0);
        ev(tf + 1, fin, 1'b0, 1'b1);
        ev(tf + 2, fin, 1'b0, 1'b0);
    endtask

    // Drives a start for the next rising edge; s is that edge's number.
    task automatic start_cfg(input logic [7:0] t, input logic [3:0] st, input logic [15:0] d,
                             input logic ab, output int s);
        s          = cyc + 1;
        cfg_target = t;
        cfg_step   = st;
        cfg_div    = d;
        cfg_start  = 1'b1;
        cfg_abort  = ab;
    endtask

    // Completes a pulse and scrambles cfg fields, which must be ignored.
    task automatic step1();
        @(negedge clk);
        cfg_start  = 1'b0;
        cfg_abort  = 1'b0;
        cfg_target = 8'hC3;
        cfg_step   = 4'h0;
        cfg_div    = 16'h0002;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    int s, r;

    initial begin
        rst_n      = 1'b0;
        cfg_target = 8'h00;
        cfg_step   = 4'h0;
        cfg_div    = 16'h0000;
        cfg_start  = 1'b0;
        cfg_abort  = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        cfg_target = 8'h55;
        cfg_step   = 4'h7;
        cfg_div    = 16'h0001;
        repeat (4) @(negedge clk);

        // Basic up-ramp 0x00 -> 0x10, step 4, every clock.
        start_cfg(8'h10, 4'd4, 16'd0, 1'b0, s);
        ramp_ev(s, 0, 8'h00, 4, 3, 8'h10);
        step1(); drain();

        // Climb to 0xFA (last step clamps), then saturate to 0xFF.
        start_cfg(8'hFA, 4'd15, 16'd0, 1'b0, s);
        ramp_ev(s, 0, 8'h10, 15, 15, 8'hFA);
        step1(); drain();
        start_cfg(8'hFF, 4'd15, 16'd0, 1'b0, s);
        ramp_ev(s, 0, 8'hFA, 15, 0, 8'hFF);
        step1(); drain();

        // Descend to 0x05 (clamped), then to 0x00 without wrapping.
        start_cfg(8'h05, 4'd15, 16'd0, 1'b0, s);
        ramp_ev(s, 0, 8'hFF, -15, 16, 8'h05);
        step1(); drain();
        start_cfg(8'h00, 4'd8, 16'd0, 1'b0, s);
        ramp_ev(s, 0, 8'h05, -8, 0, 8'h00);
        step1(); drain();

        // Divider pacing: div=3 gives changes at s+4, s+8, s+12.
        start_cfg(8'h03, 4'd1, 16'd3, 1'b0, s);
        ramp_ev(s, 3, 8'h00, 1, 2, 8'h03);
        step1(); drain();

        // Target equal to current duty: no busy, single done pulse.
        start_cfg(8'h03, 4'd5, 16'd0, 1'b0, s);
        ev(s + 1, 8'h03, 1'b0, 1'b1);
        ev(s + 2, 8'h03, 1'b0, 1'b0);
        step1(); drain();

        // Step of 0 behaves as 1.
        start_cfg(8'h00, 4'd0, 16'd0, 1'b0, s);
        ramp_ev(s, 0, 8'h03, -1, 2, 8'h00);
        step1(); drain();

        // Abort at duty 0x20 (div=1, step 8): frozen, no done.
        start_cfg(8'h80, 4'd8, 16'd1, 1'b0, s);
        ev(s,     8'h00, 1'b1, 1'b0);
        ev(s + 2, 8'h08, 1'b1, 1'b0);
        ev(s + 4, 8'h10, 1'b1, 1'b0);
        ev(s + 6, 8'h18, 1'b1, 1'b0);
        ev(s + 8, 8'h20, 1'b1, 1'b0);
        ev(s + 9, 8'h20, 1'b0, 1'b0);
        step1();
        while (cyc < s + 8) @(negedge clk);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        repeat (10) @(negedge clk);

        // Start and abort together in IDLE: nothing happens.
        start_cfg(8'h50, 4'd4, 16'd0, 1'b1, s);
        step1();
        repeat (10) @(negedge clk);

        // Retarget mid-ramp at 0x40 toward 0x30: direction reverses.
        start_cfg(8'h80, 4'd8, 16'd0, 1'b0, s);
        ev(s,     8'h20, 1'b1, 1'b0);
        ev(s + 1, 8'h28, 1'b1, 1'b0);
        ev(s + 2, 8'h30, 1'b1, 1'b0);
        ev(s + 3, 8'h38, 1'b1, 1'b0);
        ev(s + 4, 8'h40, 1'b1, 1'b0);
        step1();
        while (cyc < s + 4) @(negedge clk);
        start_cfg(8'h30, 4'd8, 16'd0, 1'b0, r);
        ev(r + 1, 8'h38, 1'b1, 1'b0);
        ev(r + 2, 8'h30, 1'b0, 1'b0);
        ev(r + 3, 8'h30, 1'b0, 1'b1);
        ev(r + 4, 8'h30, 1'b0, 1'b0);
        step1(); drain();

        // Reset mid-ramp: duty clears, no done afterwards.
        start_cfg(8'h90, 4'd8, 16'd1, 1'b0, s);
        ev(s,     8'h30, 1'b1, 1'b0);
        ev(s + 2, 8'h38, 1'b1, 1'b0);
        ev(s + 4, 8'h40, 1'b1, 1'b0);
        ev(s + 5, 8'h00, 1'b0, 1'b0);
        step1();
        while (cyc < s + 4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Ramp after reset still works.
        start_cfg(8'h02, 4'd1, 16'd0, 1'b0, s);
        ramp_ev(s, 0, 8'h00, 1, 1, 8'h02);
        step1(); drain();

        end_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
